// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier family.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    typedef enum logic [2:0] {
        ZERO,
        POS1,
        POS2,
        NEG1,
        NEG2
    } digit_e;

    // Operand width plus two guard bits for the -2M and unsigned-MSB cases.
    function automatic int unsigned width_ext(input int unsigned w);
        return w + 2;
    endfunction

    function automatic digit_e booth_digit(input logic [2:0] bits);
        case (bits)
            3'b001, 3'b010: return POS1;
            3'b011:         return POS2;
            3'b100:         return NEG2;
            3'b101, 3'b110: return NEG1;
            default:        return ZERO;
        endcase
    endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth recode: maps a 3-bit window and multiplicand to a signed partial multiple.
module booth_r4_encoder
    import booth_pkg::*;
#(
    parameter int unsigned E = 10
) (
    input  logic [2:0]   bits,
    input  logic [E-1:0] m,
    output logic [E:0]   pp_c
);

    logic [E:0] m1_c;
    logic [E:0] m2_c;

    always_comb begin
        m1_c = {m[E-1], m};
        m2_c = {m, 1'b0};
        pp_c = '0;
        unique case (booth_digit(bits))
            POS1:    pp_c = m1_c;
            POS2:    pp_c = m2_c;
            NEG1:    pp_c = -m1_c;
            NEG2:    pp_c = -m2_c;
            default: pp_c = '0;
        endcase
    end

endmodule

// File: rtl/booth_radix4_multiplier.sv
// Iterative radix-4 Booth multiplier, one digit per clock, signed or unsigned operands.
module booth_radix4_multiplier
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned E  = width_ext(WIDTH);
    localparam int unsigned PW = 2 * E + 1;
    localparam int unsigned N  = E / 2;
    localparam int unsigned CW = $clog2(N + 1);

    state_e             state_q, state_d;
    logic [E-1:0]       m_q, m_d;
    logic [PW-1:0]      p_q, p_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic [E:0]         pp_c;
    logic [E:0]         sum_c;
    logic [PW-1:0]      p_step_c;
    logic [E-1:0]       a_ext_c;
    logic [E-1:0]       b_ext_c;
    logic               last_c;

    booth_r4_encoder #(.E(E)) u_enc (
        .bits (p_q[2:0]),
        .m    (m_q),
        .pp_c (pp_c)
    );

    // Datapath: add the partial multiple into a sign-extended upper half, then shift right by 2.
    always_comb begin
        a_ext_c  = signed_mode ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
        b_ext_c  = signed_mode ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};
        sum_c    = {p_q[PW-1], p_q[PW-1:E+1]} + pp_c;
        p_step_c = {sum_c[E], sum_c, p_q[E:2]};
        last_c   = (cnt_q == CW'(N - 1));
    end

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        p_d       = p_q;
        cnt_d     = cnt_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        product_d = product_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = CALC;
                    m_d     = a_ext_c;
                    p_d     = {{E{1'b0}}, b_ext_c, 1'b0};
                    cnt_d   = '0;
                end
            end
            CALC: begin
                p_d   = p_step_c;
                cnt_d = cnt_q + CW'(1);
                if (last_c) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    product_d = p_step_c[2*WIDTH:1];
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            m_q       <= '0;
            p_q       <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            p_q       <= p_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// Self-checking bench: WIDTH 4/8/16 instances against an integer-arithmetic reference model.
module tb_booth_radix4_multiplier;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sm;
    logic [15:0] a_v;
    logic [15:0] b_v;
    int          sel;

    logic        busy4, done4, busy8, done8, busy16, done16;
    logic [7:0]  prod4;
    logic [15:0] prod8;
    logic [31:0] prod16;

    logic        cur_busy, cur_done;
    logic [31:0] cur_prod;

    logic [2:0]  enc_bits;
    logic [9:0]  enc_m;
    logic [10:0] enc_pp;

    int n_checks = 0;
    int n_fail   = 0;

    booth_radix4_multiplier #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start && sel == 4), .signed_mode(sm),
        .a(a_v[3:0]), .b(b_v[3:0]), .busy(busy4), .done(done4), .product(prod4)
    );
    booth_radix4_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start && sel == 8), .signed_mode(sm),
        .a(a_v[7:0]), .b(b_v[7:0]), .busy(busy8), .done(done8), .product(prod8)
    );
    booth_radix4_multiplier #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start && sel == 16), .signed_mode(sm),
        .a(a_v), .b(b_v), .busy(busy16), .done(done16), .product(prod16)
    );
    booth_r4_encoder #(.E(10)) enc (.bits(enc_bits), .m(enc_m), .pp_c(enc_pp));

    always_comb begin
        case (sel)
            4:       begin cur_busy = busy4;  cur_done = done4;  cur_prod = 32'(prod4);  end
            16:      begin cur_busy = busy16; cur_done = done16; cur_prod = prod16;       end
            default: begin cur_busy = busy8;  cur_done = done8;  cur_prod = 32'(prod8);  end
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference product: interpret operands as w-bit signed/unsigned integers and multiply.
    function automatic logic [31:0] ref_mul(input int w, input logic s,
                                            input logic [15:0] av, input logic [15:0] bv);
        longint lim, x, y, p;
        lim = longint'(1) << w;
        x = longint'(av) & (lim - 1);
        y = longint'(bv) & (lim - 1);
        if (s && x >= lim / 2) x = x - lim;
        if (s && y >= lim / 2) y = y - lim;
        p = (x * y) & (lim * lim - 1);
        return 32'(p);
    endfunction

    // Waits for done with a cycle bound; optionally re-pulses start with junk operands at cycle poke.
    task automatic wait_done(input int poke, output int n, output int bc);
        n  = 0;
        bc = 0;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (cur_busy) bc++;
            if (cur_done) break;
            if (poke > 0) begin
                start = (n == poke);
                a_v   = 16'($urandom);
                b_v   = 16'($urandom);
            end
        end
    endtask

    task automatic run_job(input int w, input logic s, input logic [15:0] av,
                           input logic [15:0] bv, input logic [31:0] exp,
                           input int poke, input string tag);
        int n, bc;
        sel = w; sm = s; a_v = av; b_v = bv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        sm  = 1'($urandom);
        a_v = 16'($urandom);
        b_v = 16'($urandom);
        wait_done(poke, n, bc);
        start = 1'b0;
        check({tag, "_lat"},  32'(n),  32'(w / 2 + 1));
        check({tag, "_prod"}, cur_prod, exp);
        check({tag, "_busy"}, 32'(bc), 32'(w / 2));
        @(posedge clk); #1;
        check({tag, "_pulse"}, 32'(cur_done), 32'(0));
    endtask

    initial begin
        int n, bc, dn, d, ms, e;
        logic        sj  [3];
        logic [15:0] aj  [3];
        logic [15:0] bj  [3];

        rst = 1'b1; start = 1'b0; sm = 1'b0; a_v = '0; b_v = '0; sel = 8;
        enc_bits = '0; enc_m = '0;
        #1;
        check("rst_prod8",  32'(prod8), 32'(0));
        check("rst_prod16", prod16,     32'(0));
        check("rst_flags",  32'({busy4, done4, busy8, done8, busy16, done16}), 32'(0));

        // Recode table, all windows against all multiplicands.
        for (int bb = 0; bb < 8; bb++) begin
            for (int mm = 0; mm < 1024; mm++) begin
                enc_bits = 3'(bb);
                enc_m    = 10'(mm);
                #1;
                ms = (mm >= 512) ? mm - 1024 : mm;
                d  = ((bb >> 1) & 1) + (bb & 1) - 2 * ((bb >> 2) & 1);
                e  = (d * ms) & 32'h7FF;
                check("enc", 32'(enc_pp), 32'(e));
            end
        end

        @(posedge clk); #1;
        rst = 1'b0;

        run_job(8, 1'b1, 16'h0080, 16'h0080, 32'h4000, -1, "s_min_min");
        run_job(8, 1'b0, 16'h00FF, 16'h00FF, 32'hFE01, -1, "u_ff_ff");
        run_job(8, 1'b1, 16'h00FF, 16'h00FF, 32'h0001, -1, "s_m1_m1");
        run_job(8, 1'b1, 16'h00FD, 16'h0007, 32'hFFEB, -1, "s_m3_7");
        run_job(8, 1'b1, 16'h0000, 16'h00FF, 32'h0000, -1, "s_0_m1");
        run_job(8, 1'b1, 16'h0005, 16'h0006, 32'h001E, 2,  "ignore_start");

        // Abort mid-calculation after a nonzero product is held.
        run_job(8, 1'b1, 16'h00FD, 16'h0007, 32'hFFEB, -1, "pre_rst");
        sel = 8; sm = 1'b0; a_v = 16'h0011; b_v = 16'h0022; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_busy_pre", 32'(cur_busy), 32'(1));
        rst = 1'b1;
        #1;
        check("rst_abort_busy", 32'(cur_busy), 32'(0));
        check("rst_abort_done", 32'(cur_done), 32'(0));
        check("rst_abort_prod", cur_prod,      32'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        dn = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (cur_done) dn++;
        end
        check("rst_no_done", 32'(dn), 32'(0));
        run_job(8, 1'b0, 16'h0011, 16'h0022, 32'h0242, -1, "post_rst");

        // Start held high: each done is followed on the next edge by a new accept.
        for (int j = 0; j < 3; j++) begin
            sj[j] = 1'($urandom);
            aj[j] = 16'($urandom);
            bj[j] = 16'($urandom);
        end
        sel = 8; sm = sj[0]; a_v = aj[0]; b_v = bj[0]; start = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #1;
            if (j > 0) check("b2b_pulse", 32'(cur_done), 32'(0));
            if (j == 2) start = 1'b0;
            sm  = 1'($urandom);
            a_v = 16'($urandom);
            b_v = 16'($urandom);
            wait_done(-1, n, bc);
            check("b2b_lat",  32'(n), 32'(5));
            check("b2b_prod", cur_prod, ref_mul(8, sj[j], aj[j], bj[j]));
            if (j < 2) begin
                sm = sj[j + 1]; a_v = aj[j + 1]; b_v = bj[j + 1];
            end
        end
        start = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 30; i++) begin
            logic s; logic [15:0] x, y;
            s = 1'($urandom); x = 16'($urandom); y = 16'($urandom);
            run_job(8, s, x, y, ref_mul(8, s, x, y), -1, "w8_rand");
        end
        for (int i = 0; i < 150; i++) begin
            logic s; logic [15:0] x, y;
            s = 1'($urandom); x = 16'($urandom); y = 16'($urandom);
            run_job(16, s, x, y, ref_mul(16, s, x, y), -1, "w16_rand");
        end
        for (int s = 0; s < 2; s++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    run_job(4, 1'(s), 16'(x), 16'(y), ref_mul(4, 1'(s), 16'(x), 16'(y)), -1, "w4_all");
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/booth_radix4_multiplier.md
# booth_radix4_multiplier

Iterative radix-4 (modified Booth) multiplier, parametrised in operand width, with run-time selection of signed or unsigned operands. It sits alongside the fixed 8-bit Booth multiplier and replaces it wherever a start/done multiplier of another width, or with unsigned support, is needed. One Booth digit is retired per clock, and the multiplier accepts a new job on the cycle its result is presented.

## Interface
- WIDTH, default 8, operand width in bits. Must be even and ≥ 4.
- clk, input, 1, sole clock; all state changes on the rising edge.
- rst, input, 1, asynchronous, active-high reset.
- start, input, 1, request; sampled only in IDLE or DONE.
- signed_mode, input, 1, 1 = two's-complement operands, 0 = unsigned; captured with the operands.
- a, input, WIDTH, multiplicand; captured on an accepted start.
- b, input, WIDTH, multiplier; captured on an accepted start.
- busy, output, 1, high in CALC.
- done, output, 1, one-cycle pulse; product valid.
- product, output, 2*WIDTH, result register; holds until the next result is written.

## Operation
- Let E = WIDTH+2 and N = E/2 = WIDTH/2+1, the number of digits.
- On capture, operands are extended to E bits: sign-extended when signed_mode=1, zero-extended when 0.
- Internal registers:
  - M, E bits, extended a.
  - Accumulator P, 2E+1 bits, initialised to {E zeros, extended b, 1'b0}.
  - Digit counter, ceil(log2(N+1)) bits.
- Digit recode from P[2:0]:
  - 000 or 111 → 0.
  - 001 or 010 → +M.
  - 011 → +2M.
  - 100 → −2M.
  - 101 or 110 → −M.
- Per digit, in one cycle, the selected multiple is added to P[2E:E+1] modulo 2^(E+1). The +2M and −2M multiples are M<<1 and −(M<<1), sign-extended to E+1 bits. P is then arithmetically shifted right by 2.
- The result is P[2*WIDTH:1] after N digits and is exact for all operand values in both modes. The extra 2 bits of E absorb the −2M and unsigned MSB cases.
- FSM states:
  - IDLE: start=1 → CALC, load M, P and counter=0. Otherwise stay.
  - CALC: process one digit and increment the counter. On the N-th digit → DONE, writing product in the same edge.
  - DONE: done=1. start=1 → CALC with a new load (back-to-back). Otherwise → IDLE.
- start in CALC is ignored and does not queue. a, b and signed_mode may change freely after capture.
- Reset values: state IDLE, busy 0, done 0, product 0, P, M and counter 0.
- Asserting rst at any time, including mid-CALC, aborts the job. No done is produced and product returns to 0.

## Timing
- Edge k samples start (accepted). Edges k+1 … k+N process the digits.
- done=1 and product are updated from edge k+N: latency is N cycles, which is 5 for WIDTH=8.
- busy is high from edge k+1 through edge k+N−1, i.e. during CALC. It is low in DONE.
- Throughput with start held high: one result per N+1 cycles. done pulses every N+1 cycles and is never high for two consecutive cycles.
- rst deassertion needs no synchronisation inside the block; the system provides it.

## Structure
- Shared package booth_pkg holds:
  - State enum: IDLE, CALC, DONE.
  - Booth digit enum: ZERO, POS1, POS2, NEG1, NEG2.
  - Function width_ext(WIDTH) = WIDTH+2.
- One sub-module, booth_r4_encoder: combinational. Takes P[2:0] and M and outputs the signed E+1-bit partial multiple. This keeps the recode table in one place so the bench can check it exhaustively.

## Test plan
- WIDTH=8, signed: a=−128, b=−128 → product 0x4000, done exactly 5 cycles after the start edge. busy high for 4 cycles.
- WIDTH=8, unsigned: a=255, b=255 → 0xFE01. Same inputs with signed_mode=1 → 0x0001.
- WIDTH=8, signed: a=−3, b=7 → 0xFFEB. Then a=0, b=−1 → 0x0000.
- start pulsed again in CALC with different operands → ignored. The single done carries the first result. start held high for 3 jobs → done every 6 cycles, each result correct.
- rst asserted in the 3rd CALC cycle → busy, done and product go to 0 immediately. No done follows. A new start then gives the correct result.
- WIDTH=16 and WIDTH=4: random operands and random signed_mode (exhaustive for WIDTH=4) checked against a behavioural model. done always appears at start edge + WIDTH/2+1.
